// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC engine and the filter controller:
// state encoding, Sobel-X defaults, accumulator sizing and saturation limits.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_t;

  localparam int SOBEL_N = 9;

  function automatic int sobel_x(input int k);
    case (k)
      0: return -1;
      1: return 0;
      2: return 1;
      3: return -2;
      4: return 0;
      5: return 2;
      6: return -1;
      7: return 0;
      8: return 1;
      default: return 0;
    endcase
  endfunction

  // Wide enough that M*N full-scale products can never wrap.
  function automatic int acc_w(input int m, input int n, input int dw);
    return 2 * dw + $clog2(m * n);
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (2 * dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (2 * dw - 1));
  endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// Registered signed multiply-accumulate with clear, plus saturation
// of the accumulator down to a 2*DATA_WIDTH result register.
module conv_mac_sat
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W      = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clr,
  input  logic                           i_en,
  input  logic                           i_load,
  input  logic signed [DATA_WIDTH-1:0]   i_a,
  input  logic signed [DATA_WIDTH-1:0]   i_b,
  output logic signed [2*DATA_WIDTH-1:0] o_result,
  output logic                           o_sat
);

  localparam int OW = 2 * DATA_WIDTH;

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    ACC_W'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    ACC_W'(sat_min(DATA_WIDTH));
  localparam logic signed [OW-1:0] OUT_MAX =
    OW'(sat_max(DATA_WIDTH));
  localparam logic signed [OW-1:0] OUT_MIN =
    OW'(sat_min(DATA_WIDTH));

  logic signed [OW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_hi;
  logic                    w_lo;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [OW-1:0]    r_result;
  logic                    r_sat;

  assign w_prod = OW'(i_a) * OW'(i_b);
  assign w_sum  = r_acc + ACC_W'(w_prod);
  assign w_hi   = r_acc > ACC_MAX;
  assign w_lo   = r_acc < ACC_MIN;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else begin
      if (i_clr)
        r_acc <= '0;
      else if (i_en)
        r_acc <= w_sum;
      if (i_load) begin
        r_result <= w_hi ? OUT_MAX :
                    w_lo ? OUT_MIN :
                    r_acc[OW-1:0];
        r_sat    <= w_hi | w_lo;
      end
    end
  end

  assign o_result = r_result;
  assign o_sat    = r_sat;

endmodule

// File: rtl/conv_mac_engine.sv
// Sequential M x N window-times-kernel MAC responder: latches a window,
// runs one product per cycle, then strobes the saturated sum.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int M          = 3,
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          kernel_in,
  input  logic [$clog2(M*N)-1:0]         kernel_addr,
  input  logic                           kernel_wen,
  input  logic [M*N*DATA_WIDTH-1:0]      win_data,
  input  logic                           win_valid,
  output logic                           win_ready,
  output logic [2*DATA_WIDTH-1:0]        matrix_result,
  output logic                           matrix_valid,
  output logic                           matrix_sat,
  output logic                           busy
);

  localparam int K     = M * N;
  localparam int AW    = $clog2(K);
  localparam int DW    = DATA_WIDTH;
  localparam int ACC_W = acc_w(M, N, DATA_WIDTH);

  state_t                r_state;
  state_t                w_next;
  logic [AW-1:0]         r_idx;
  logic [K*DW-1:0]       r_win;
  logic signed [DW-1:0]  r_kern [K];
  logic                  r_valid;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_kwr;
  logic signed [DW-1:0]  w_a;
  logic signed [DW-1:0]  w_b;
  logic signed [2*DW-1:0] w_result;
  logic                  w_sat;

  assign w_accept = (r_state == S_IDLE) && win_valid;
  assign w_last   = r_idx == AW'(K - 1);
  assign w_kwr    = (r_state == S_IDLE) && kernel_wen &&
                    (int'(kernel_addr) < K);
  assign w_a      = r_win[int'(r_idx) * DW +: DW];
  assign w_b      = r_kern[r_idx];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (win_valid) w_next = S_MAC;
      S_MAC:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_win   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= r_state == S_DONE;
      if (w_accept) begin
        r_win <= win_data;
        r_idx <= '0;
      end else if (r_state == S_MAC) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  // A write landing on the accept edge is visible to that window,
  // since the first coefficient read happens one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < K; k++)
        r_kern[k] <= (K == SOBEL_N) ? DW'(sobel_x(k)) : '0;
    end else if (w_kwr) begin
      r_kern[kernel_addr] <= kernel_in;
    end
  end

  conv_mac_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_accept),
    .i_en     (r_state == S_MAC),
    .i_load   (r_state == S_DONE),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_result),
    .o_sat    (w_sat)
  );

  assign win_ready     = r_state == S_IDLE;
  assign busy          = r_state != S_IDLE;
  assign matrix_valid  = r_valid;
  assign matrix_result = w_result;
  assign matrix_sat    = w_sat;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Randomised bench for conv_mac_engine against a plain-arithmetic
// dot-product model with output saturation.
module tb_conv_mac_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  kernel_in = '0;
  logic [3:0]  kernel_addr = '0;
  logic        kernel_wen = 1'b0;
  logic [71:0] win_data = '0;
  logic        win_valid = 1'b0;
  logic        win_ready;
  logic [15:0] matrix_result;
  logic        matrix_valid;
  logic        matrix_sat;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int km [9];
  int win [9];
  int q_cyc [$];
  int q_res [$];
  int q_sat [$];

  conv_mac_engine #(.M(3), .N(3), .DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .kernel_in     (kernel_in),
    .kernel_addr   (kernel_addr),
    .kernel_wen    (kernel_wen),
    .win_data      (win_data),
    .win_valid     (win_valid),
    .win_ready     (win_ready),
    .matrix_result (matrix_result),
    .matrix_valid  (matrix_valid),
    .matrix_sat    (matrix_sat),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (matrix_valid) begin
      q_cyc.push_back(cyc);
      q_res.push_back(int'(matrix_result));
      q_sat.push_back(int'(matrix_sat));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void sobel_model();
    int sx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    for (int k = 0; k < 9; k++) km[k] = sx[k];
  endfunction

  function automatic void model(output int r, output int s);
    longint sum = 0;
    for (int k = 0; k < 9; k++) sum += longint'(win[k]) * longint'(km[k]);
    if (sum > 32767) begin
      r = 32767; s = 1;
    end else if (sum < -32768) begin
      r = -32768; s = 1;
    end else begin
      r = int'(sum); s = 0;
    end
  endfunction

  function automatic logic [71:0] pack();
    logic [71:0] p;
    for (int k = 0; k < 9; k++) p[k*8 +: 8] = 8'(win[k]);
    return p;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic kwrite(input int a, input int v);
    kernel_wen = 1'b1;
    kernel_addr = 4'(a);
    kernel_in = 8'(v);
    @(posedge clk); #1;
    kernel_wen = 1'b0;
    if (a < 9) km[a] = v;
  endtask

  task automatic send(input string tag, output int t,
                      input int wa, input int wv);
    chk({tag, "_ready"}, win_ready, 1);
    win_data = pack();
    win_valid = 1'b1;
    if (wa >= 0) begin
      kernel_wen = 1'b1;
      kernel_addr = 4'(wa);
      kernel_in = 8'(wv);
      if (wa < 9) km[wa] = wv;
    end
    @(posedge clk); #1;
    t = cyc;
    win_valid = 1'b0;
    kernel_wen = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int t0,
                               input int er, input int es);
    int n = 0;
    while (q_cyc.size() == 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (q_cyc.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_lat"}, q_cyc.pop_front() - t0, 10);
      chk({tag, "_res"}, q_res.pop_front(), er & 32'hFFFF);
      chk({tag, "_sat"}, q_sat.pop_front(), es);
    end
  endtask

  task automatic run(input string tag, input int wa, input int wv);
    int t, er, es;
    send(tag, t, wa, wv);
    model(er, es);
    expect_result(tag, t, er, es);
  endtask

  task automatic set_rows();
    for (int k = 0; k < 9; k++) win[k] = 10 * ((k % 3) + 1);
  endtask

  initial begin
    int t, ta, ra, sa, rb, sb;
    logic [71:0] pa, pb;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", matrix_result, 0);
    chk("rst_valid", matrix_valid, 0);
    chk("rst_sat", matrix_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", win_ready, 1);
    rst = 1'b0;
    sobel_model();

    set_rows();
    send("sobel", t, -1, 0);
    chk("busy_after_accept", busy, 1);
    expect_result("sobel", t, 80, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pulse_width", q_cyc.size(), 0);
    chk("hold_result", matrix_result, 80);

    for (int a = 0; a < 9; a++) kwrite(a, 1);
    for (int k = 0; k < 9; k++) win[k] = 127;
    run("ones", -1, 0);
    kwrite(4, -1);
    run("center_neg", -1, 0);

    for (int a = 0; a < 9; a++) kwrite(a, -128);
    for (int k = 0; k < 9; k++) win[k] = -128;
    run("sat_pos", -1, 0);
    for (int a = 0; a < 9; a++) kwrite(a, 127);
    run("sat_neg", -1, 0);

    kwrite(12, 77);
    kwrite(9, -5);
    run("bad_addr", -1, 0);

    for (int k = 0; k < 9; k++) win[k] = rnd8();
    run("same_edge", 2, 55);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) kwrite(int'($urandom_range(0, 15)), rnd8());
      for (int k = 0; k < 9; k++) win[k] = rnd8();
      run($sformatf("rand%0d", i), -1, 0);
    end

    for (int k = 0; k < 9; k++) win[k] = rnd8();
    pa = pack();
    model(ra, sa);
    for (int k = 0; k < 9; k++) win[k] = rnd8();
    pb = pack();
    model(rb, sb);
    chk("b2b_ready", win_ready, 1);
    win_data = pa;
    win_valid = 1'b1;
    @(posedge clk); #1;
    ta = cyc;
    for (int i = 1; i <= 10; i++) begin
      win_data = {8'($urandom), 32'($urandom), 32'($urandom)};
      if (i >= 2 && i <= 9) begin
        kernel_wen = 1'b1;
        kernel_addr = 4'($urandom_range(0, 8));
        kernel_in = 8'($urandom);
      end else begin
        kernel_wen = 1'b0;
      end
      if (i == 5) begin
        chk("busy_mac", busy, 1);
        chk("ready_mac", win_ready, 0);
      end
      @(posedge clk); #1;
    end
    kernel_wen = 1'b0;
    win_data = pb;
    @(posedge clk); #1;
    win_valid = 1'b0;
    expect_result("b2b_a", ta, ra, sa);
    expect_result("b2b_b", ta + 11, rb, sb);
    repeat (15) @(posedge clk);
    #1;
    chk("b2b_extra", q_cyc.size(), 0);

    for (int k = 0; k < 9; k++) win[k] = rnd8();
    send("midrst", t, -1, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", win_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", matrix_valid, 0);
    chk("midrst_result", matrix_result, 0);
    chk("midrst_sat", matrix_sat, 0);
    sobel_model();
    repeat (15) @(posedge clk);
    #1;
    chk("midrst_no_pulse", q_cyc.size(), 0);
    set_rows();
    run("post_rst", -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_mac_engine.md
# conv_mac_engine

Sequential multiply-accumulate responder for the 3x3 image filter. It accepts one M×N pixel window, multiplies it element-wise against a locally held signed kernel, accumulates over M*N cycles and saturates the sum. It returns the sum on `matrix_result` with a one-cycle `matrix_valid` pulse, which is the result port the filter controller waits on in its WAIT_RESULT state.

## Interface
- `M`, 3: kernel/window rows
- `N`, 3: kernel/window columns
- `DATA_WIDTH`, 8: signed pixel and kernel coefficient width
- `clk` input 1: single clock; all logic is on the rising edge
- `rst` input 1: synchronous, active-high reset
- `kernel_in` input DATA_WIDTH: signed coefficient to write
- `kernel_addr` input $clog2(M*N): coefficient index
- `kernel_wen` input 1: coefficient write strobe
- `win_data` input M*N*DATA_WIDTH: window; element k = r*N+c at bits [k*DATA_WIDTH +: DATA_WIDTH], signed
- `win_valid` input 1: window offered
- `win_ready` output 1: engine can accept a window
- `matrix_result` output 2*DATA_WIDTH: saturated signed sum
- `matrix_valid` output 1: one-cycle result strobe
- `matrix_sat` output 1: saturation occurred; qualified by `matrix_valid`
- `busy` output 1: a window is held or being processed

## Operation
- States:
  - IDLE: `win_ready`=1. A window is accepted on an edge where `win_valid`=1; it is latched into a local window register, the accumulator and index are cleared, and the state goes to MAC.
  - MAC: one product per cycle, acc += win[idx]*kernel[idx], with idx running 0..M*N-1. After idx = M*N-1 the state goes to DONE.
  - DONE: `matrix_result`, `matrix_sat` and `matrix_valid`=1 are driven for exactly one cycle, then the state returns to IDLE.
- Arithmetic:
  - Each product is a full signed 2*DATA_WIDTH result.
  - The accumulator is ACC_W = 2*DATA_WIDTH + $clog2(M*N) bits, signed, and never overflows internally.
  - Saturation happens only at output:
    - acc > 2^(2*DATA_WIDTH-1)-1 gives max positive and `matrix_sat`=1.
    - acc < -2^(2*DATA_WIDTH-1) gives max negative and `matrix_sat`=1.
    - Otherwise the output is truncated exactly and `matrix_sat`=0.
- Kernel memory:
  - Writes are honoured only in IDLE.
  - `kernel_wen` in MAC or DONE is ignored.
  - `kernel_addr` >= M*N is ignored.
  - A write and a window accept on the same IDLE edge: the write lands first, so that window sees the new coefficient.
- `win_valid` outside IDLE is ignored. No queuing; the source must hold `win_valid` until it sees `win_ready`.
- `busy` = (state != IDLE).

## Timing
- Reset, synchronous at any state including mid-MAC:
  - State goes to IDLE and any pending result is dropped; no `matrix_valid` pulse follows.
  - `matrix_result`=0, `matrix_valid`=0, `matrix_sat`=0, `busy`=0.
  - `win_ready`=1 in the first cycle after the reset edge.
  - Kernel reloads Sobel-X {-1,0,1,-2,0,2,-1,0,1} when M*N=9, otherwise all zeros.
- Latency, with the window accepted at edge t:
  - MAC edges are t+1 … t+M*N.
  - `matrix_valid` is high in the cycle after edge t+M*N+1, so 10 edges after accept for 3x3.
- `matrix_result` and `matrix_sat` hold their values after the pulse until the next DONE or reset.
- Back-to-back throughput: one window every M*N+2 cycles. `win_ready` returns in the cycle following the DONE cycle.
- All outputs are registered; there are no combinational input-to-output paths except that `win_ready` is decoded from state.

## Structure
- Shared package `conv_pkg`:
  - state encoding (IDLE, MAC, DONE)
  - Sobel-X default coefficient constants
  - ACC_W derivation function
  - saturation limit constants as functions of DATA_WIDTH
- The image filter controller imports the same package for its kernel defaults.
- One sub-module, `conv_mac_sat`: registered signed multiply-accumulate with clear, plus output saturation. It is parameterised on DATA_WIDTH and ACC_W.
- The FSM, window register and kernel memory live in `conv_mac_engine`.

## Test plan
- Reset:
  - Assert `rst` for 2 cycles → all outputs 0, `win_ready`=1.
  - Window rows [10,20,30]×3 → `matrix_result`=80, which confirms the Sobel-X reset kernel.
- Latency:
  - Sobel-X kernel, window rows [10,20,30],[10,20,30],[10,20,30] → `matrix_result`=16'd80, `matrix_sat`=0.
  - `matrix_valid` high for exactly 1 cycle, 10 edges after accept.
- Kernel load:
  - Write 1 to addr 0..8, then send window all 127 → 1143.
  - Write -1 to addr 4 only, then repeat → 889.
- Saturation, positive: kernel all -128, window all -128 → 16'h7FFF, `matrix_sat`=1.
- Saturation, negative: kernel all 127, window all -128 → 16'h8000, `matrix_sat`=1.
- Busy rules:
  - Hold `win_valid`=1 with `win_data` changing mid-MAC, and pulse `kernel_wen` during MAC.
  - Required response: result is from the latched window and old kernel, and exactly one accept per `win_ready` cycle.
  - A second window is accepted the cycle after DONE.
- Reset mid-operation:
  - Assert `rst` at MAC idx 4 → no `matrix_valid` pulse.
  - `win_ready`=1 the next cycle.
  - A new window then produces the correct result on normal latency.
